// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM, with independent read and write FSMs.
// Define AXI_SLAVE_RAND_DELAY_EN to add LFSR-driven 0-3 cycle jitter to response latencies.
module axi4_sram_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    READ_LAT   = 2,
    parameter int                    WRITE_LAT  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  awready,
    input  logic                  awvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [3:0]            awid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    output logic                  wready,
    input  logic                  wvalid,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    output logic [3:0]            bid,
    output logic                  arready,
    input  logic                  arvalid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [3:0]            rid
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + ((ADDR_WIDTH+1)'(DEPTH) << 2);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + ADDR_WIDTH'(4);
    endfunction

    logic [31:0] mem [DEPTH];

    logic unused_sizes;
    assign unused_sizes = ^{awsize, arsize};

    logic [1:0] extra;
`ifdef AXI_SLAVE_RAND_DELAY_EN
    logic [7:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign extra = lfsr[1:0];
`else
    assign extra = 2'd0;
`endif

    logic [7:0] r_lat_load, w_lat_load;
    assign r_lat_load = 8'(READ_LAT)  + {6'd0, extra};
    assign w_lat_load = 8'(WRITE_LAT) + {6'd0, extra};

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [7:0]            r_cnt, r_beat, r_len;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt, r_sample_addr;
    logic [1:0]            r_burst;
    logic [3:0]            r_id;
    logic                  r_sample;

    assign r_addr_nxt = next_addr(r_addr, r_burst);

    always_comb begin
        r_next        = r_state;
        r_sample      = 1'b0;
        r_sample_addr = r_addr;
        case (r_state)
            R_IDLE: if (arvalid) begin
                r_sample_addr = araddr;
                if (r_lat_load == 8'd0) begin
                    r_next   = R_DATA;
                    r_sample = 1'b1;
                end else begin
                    r_next = R_WAIT;
                end
            end
            R_WAIT: if (r_cnt <= 8'd1) begin
                r_next   = R_DATA;
                r_sample = 1'b1;
            end
            R_DATA: if (rready) begin
                if (r_beat == r_len) begin
                    r_next = R_IDLE;
                end else begin
                    // next beat is fetched from the advanced address, optionally after a gap
                    r_sample_addr = r_addr_nxt;
                    if (extra == 2'd0) r_sample = 1'b1;
                    else               r_next   = R_WAIT;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_next;
            case (r_state)
                R_IDLE: if (arvalid) begin
                    r_addr  <= araddr;
                    r_id    <= arid;
                    r_len   <= arlen;
                    r_burst <= arburst;
                    r_beat  <= '0;
                    r_cnt   <= r_lat_load;
                end
                R_WAIT: r_cnt <= r_cnt - 8'd1;
                R_DATA: if (rready && (r_beat != r_len)) begin
                    r_addr <= r_addr_nxt;
                    r_beat <= r_beat + 8'd1;
                    r_cnt  <= {6'd0, extra};
                end
                default: ;
            endcase
            // registered read: a same-cycle write to this word lands after, so old data is returned
            if (r_sample) begin
                rdata <= in_range(r_sample_addr) ? mem[word_idx(r_sample_addr)] : 32'd0;
                rresp <= in_range(r_sample_addr) ? 2'b00 : 2'b10;
            end
        end
    end

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rlast   = rvalid && (r_beat == r_len);
    assign rid     = r_id;

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [7:0]            w_cnt, w_beat, w_len;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_burst;
    logic [3:0]            w_id;
    logic                  w_err, mem_we;

    always_comb begin
        w_next = w_state;
        mem_we = 1'b0;
        case (w_state)
            W_IDLE: if (awvalid) w_next = W_DATA;
            W_DATA: if (wvalid) begin
                mem_we = in_range(w_addr);
                if (w_beat == w_len) w_next = (w_lat_load == 8'd0) ? W_RESP : W_LAT;
            end
            W_LAT:  if (w_cnt <= 8'd1) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_cnt   <= '0;
            w_beat  <= '0;
            w_len   <= '0;
            w_addr  <= '0;
            w_burst <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_next;
            case (w_state)
                W_IDLE: if (awvalid) begin
                    w_addr  <= awaddr;
                    w_id    <= awid;
                    w_len   <= awlen;
                    w_burst <= awburst;
                    w_beat  <= '0;
                    w_err   <= 1'b0;
                end
                W_DATA: if (wvalid) begin
                    w_addr <= next_addr(w_addr, w_burst);
                    w_beat <= w_beat + 8'd1;
                    w_err  <= w_err | ~in_range(w_addr) | (wlast ^ (w_beat == w_len));
                    if (w_beat == w_len) w_cnt <= w_lat_load;
                end
                W_LAT:  w_cnt <= w_cnt - 8'd1;
                W_RESP: if (bready) w_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // SRAM contents survive reset; writes are simply blocked while it is asserted
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign awready = (w_state == W_IDLE);
    assign wready  = (w_state == W_DATA);
    assign bvalid  = (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = (bvalid && w_err) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: drivers push expected responses from a word-map
// model, a negedge monitor pops and compares every R/B handshake and checks timing/stability.
module tb_axi4_sram_slave;
    localparam int RL = 2, WL = 2, DL2 = 12;
    localparam longint unsigned BASE = 64'h8000_0000;
    localparam longint unsigned LIM  = BASE + 4 * (64'd1 << DL2);

    logic        clock = 0, reset = 1;
    logic        awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bvalid, bready = 0;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
    logic [3:0]  awid = 0, arid = 0, wstrb = 0, bid, rid;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 3'd2, arsize = 3'd2;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
    logic        arready, arvalid = 0, rvalid, rready = 0, rlast;

    always #5 clock = ~clock;

    axi4_sram_slave #(.ADDR_WIDTH(32), .DEPTH_LOG2(DL2), .BASE_ADDR(32'h8000_0000),
                      .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid));

    typedef struct { logic [31:0] d; bit known; logic [1:0] resp; bit last; logic [3:0] id; } r_exp_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;

    r_exp_t      exp_r[$];
    b_exp_t      exp_b[$];
    r_exp_t      er;
    b_exp_t      eb;
    logic [31:0] mdl [int];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int          n_chk = 0, n_pass = 0, cyc = 0;

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic bit inr(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= BASE) && (x < LIM);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((64'(a) - BASE) >> 2);
    endfunction

    // ---------------- monitor ----------------
    int          t_ar = 0, t_w = 0;
    bit          r_first = 0, r_due = 0, b_seen = 0, r_hold = 0, b_hold = 0;
    logic [38:0] r_prev;
    logic [5:0]  b_prev;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            r_first = 0; r_due = 0; b_seen = 0; r_hold = 0; b_hold = 0;
        end else begin
            if (r_hold) chk_eq("r_stable", {rdata, rresp, rlast, rid}, r_prev);
            if (b_hold) chk_eq("b_stable", {bid, bresp}, b_prev);
            if (bvalid) chk_eq("awready_during_b", awready, 0);
            if (rvalid) chk_eq("arready_during_r", arready, 0);
            if (r_due) chk_eq("r_no_gap", rvalid, 1);
            r_due = 0;
            if (rvalid && r_first) begin chk_eq("r_latency", cyc, t_ar + 1 + RL); r_first = 0; end
            if (bvalid && !b_seen) begin chk_eq("b_latency", cyc, t_w + 1 + WL); b_seen = 1; end
            if (arvalid && arready) begin t_ar = cyc; r_first = 1; end
            if (wvalid && wready) t_w = cyc;
            if (rvalid && rready) begin
                if (exp_r.size() == 0) chk_eq("r_unexpected", 1, 0);
                else begin
                    er = exp_r.pop_front();
                    chk_eq("rresp", rresp, er.resp);
                    chk_eq("rlast", rlast, er.last);
                    chk_eq("rid", rid, er.id);
                    if (er.known) chk_eq("rdata", rdata, er.d);
                end
                r_due = !rlast;
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) chk_eq("b_unexpected", 1, 0);
                else begin
                    eb = exp_b.pop_front();
                    chk_eq("bresp", bresp, eb.resp);
                    chk_eq("bid", bid, eb.id);
                end
                b_seen = 0;
            end
            r_hold = rvalid && !rready;  r_prev = {rdata, rresp, rlast, rid};
            b_hold = bvalid && !bready;  b_prev = {bid, bresp};
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [1:0] burst, input bit bad_last, input int bstall,
                            input bit rnd_w);
        logic [31:0] a, w;
        bit err;
        int b, g, k;
        b_exp_t e;
        a = addr; err = 0;
        for (int i = 0; i <= len; i++) begin
            if (inr(a)) begin
                k = widx(a);
                if (mdl.exists(k)) begin
                    w = mdl[k];
                    for (int j = 0; j < 4; j++) if (ws[i][j]) w[8*j +: 8] = wd[i][8*j +: 8];
                    mdl[k] = w;
                end else if (ws[i] == 4'hF) mdl[k] = wd[i];
            end else err = 1;
            a = (burst == 2'b00) ? a : a + 32'd4;
        end
        if (bad_last) err = 1;
        e.resp = err ? 2'b10 : 2'b00; e.id = id;
        exp_b.push_back(e);

        @(posedge clock); #1;
        awvalid = 1; awaddr = addr; awid = id; awlen = 8'(len); awburst = burst;
        wvalid = 1; wdata = 32'hBAD0_BAD0; wstrb = 4'hF; wlast = 1;
        g = 0;
        do begin
            @(negedge clock); g++;
            chk_eq("w_before_aw", wready, 0);
        end while (!awready && g < 200);
        if (!awready) begin chk_eq("aw_timeout", 0, 1); return; end
        @(posedge clock); #1;
        awvalid = 0;
        b = 0; g = 0;
        while (b <= len) begin
            if (rnd_w && $urandom_range(0, 3) == 0) wvalid = 0;
            else begin
                wvalid = 1; wdata = wd[b]; wstrb = ws[b];
                wlast = (b == len) ^ (bad_last && b == len);
            end
            @(negedge clock);
            if (wvalid && wready) b++;
            @(posedge clock); #1;
            if (++g > 300) begin chk_eq("w_timeout", b, len + 1); break; end
        end
        wvalid = 0; wlast = 0;
        g = 0;
        do begin @(negedge clock); g++; end while (!bvalid && g < 200);
        if (!bvalid) begin chk_eq("b_timeout", 0, 1); return; end
        for (int i = 1; i < bstall; i++) begin @(posedge clock); #1; @(negedge clock); end
        @(posedge clock); #1; bready = 1;
        @(negedge clock);
        @(posedge clock); #1; bready = 0;
        @(negedge clock);
        chk_eq("awready_after_b", awready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n,
                           input bit rnd_rr, input int abort_beat);
        logic [31:0] a;
        int got, stalled, g, k;
        r_exp_t e;
        a = addr; got = 0; stalled = 0;
        for (int i = 0; i <= len; i++) begin
            e.id = id; e.last = (i == len);
            if (inr(a)) begin
                k = widx(a); e.resp = 2'b00; e.known = mdl.exists(k);
                e.d = e.known ? mdl[k] : 32'd0;
            end else begin
                e.resp = 2'b10; e.known = 1; e.d = 32'd0;
            end
            exp_r.push_back(e);
            a = (burst == 2'b00) ? a : a + 32'd4;
        end
        @(posedge clock); #1;
        arvalid = 1; araddr = addr; arid = id; arlen = 8'(len); arburst = burst; rready = 1;
        g = 0;
        do begin @(negedge clock); g++; end while (!arready && g < 200);
        if (!arready) begin chk_eq("ar_timeout", 0, 1); return; end
        @(posedge clock); #1;
        arvalid = 0;
        g = 0;
        while (got <= len) begin
            @(negedge clock);
            if (rvalid && rready) got++;
            if (got > len) break;
            if (++g > 300) begin chk_eq("r_timeout", got, len + 1); break; end
            @(posedge clock); #1;
            if (got == abort_beat && rvalid) begin
                reset = 1;
                @(posedge clock); #1;
                reset = 0; rready = 0;
                exp_r.delete();
                return;
            end
            if (got == stall_beat && stalled < stall_n && rvalid) begin rready = 0; stalled++; end
            else rready = rnd_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        @(posedge clock); #1;
        rready = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk_eq("rst_arready", arready, 1);
        chk_eq("rst_awready", awready, 1);
        chk_eq("rst_outs", {rvalid, bvalid, wready, rlast, rresp, bresp, rdata, rid, bid}, 0);

        // single write then read back
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(32'h8000_0010, 4'd1, 0, 2'b01, 0, 1, 0);
        do_read(32'h8000_0010, 4'd0, 0, 2'b01, -1, 0, 0, -1);
        // partial strobe merge
        wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
        do_write(32'h8000_0010, 4'd2, 0, 2'b01, 0, 1, 0);
        do_read(32'h8000_0010, 4'd3, 0, 2'b01, -1, 0, 0, -1);
        // INCR burst preload and read with a stall on beat 2
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h8000_0000, 4'd4, 3, 2'b01, 0, 2, 0);
        do_read(32'h8000_0000, 4'd5, 3, 2'b01, 1, 2, 0, -1);
        // out of range read and write (the write aliases word 0 and must not land)
        do_read(32'h7FFF_FFFC, 4'd6, 0, 2'b01, -1, 0, 0, -1);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(32'h8001_0000, 4'd7, 0, 2'b01, 0, 1, 0);
        do_read(32'h8000_0000, 4'd8, 0, 2'b01, -1, 0, 0, -1);
        // B backpressure
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        do_write(32'h8000_0020, 4'd9, 0, 2'b01, 0, 5, 0);
        // reset during beat 2 of a 4-beat read
        do_read(32'h8000_0000, 4'd10, 3, 2'b01, -1, 0, 0, 1);
        @(negedge clock);
        chk_eq("abort_rvalid", rvalid, 0);
        chk_eq("abort_arready", arready, 1);
        chk_eq("abort_awready", awready, 1);
        do_read(32'h8000_0004, 4'd11, 0, 2'b01, -1, 0, 0, -1);
        // FIXED write burst, wlast mismatch, burst crossing the top of the array
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h8000_0040, 4'd12, 2, 2'b00, 0, 1, 0);
        do_write(32'h8000_0044, 4'd13, 1, 2'b01, 1, 1, 0);
        do_read(32'h8000_0040, 4'd14, 1, 2'b01, -1, 0, 0, -1);
        do_read(32'h8000_3FF8, 4'd15, 3, 2'b10, -1, 0, 0, -1);

        for (int t = 0; t < 60; t++) begin
            int len, sel;
            logic [31:0] a;
            logic [1:0] bu;
            len = $urandom_range(0, 7);
            sel = $urandom_range(0, 9);
            bu  = 2'($urandom_range(0, 3));
            if (sel < 7)      a = 32'(BASE + 4 * $urandom_range(0, 47)) | 32'($urandom_range(0, 3));
            else if (sel < 8) a = 32'(LIM - 4 * $urandom_range(1, 3));
            else if (sel < 9) a = 32'(BASE - 4 * $urandom_range(1, 2));
            else              a = 32'(LIM + 4 * $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
                do_write(a, 4'($urandom_range(0, 15)), len, bu, $urandom_range(0, 7) == 0,
                         $urandom_range(1, 3), 1);
            end else begin
                do_read(a, 4'($urandom_range(0, 15)), len, bu, -1, 0, 1, -1);
            end
        end

        repeat (4) @(negedge clock);
        chk_eq("r_queue_drained", exp_r.size(), 0);
        chk_eq("b_queue_drained", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
